// File: rtl/dtcm_responder_if.sv
// rtl/dtcm_responder_if.sv - DTCM core port plus external loader/debug port bundle
interface dtcm_responder_if;
  // core side
  logic        dtcm_en;
  logic [3:0]  dtcm_we;
  logic [31:0] dtcm_addr;
  logic [31:0] dtcm_wdata;
  logic [31:0] dtcm_rdata;
  // external request channel
  logic        ext_valid;
  logic        ext_ready;
  logic [3:0]  ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  // external read response channel
  logic        ext_rvalid;
  logic        ext_rready;
  logic [31:0] ext_rdata;

  modport master (
    output dtcm_en, dtcm_we, dtcm_addr, dtcm_wdata,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_rready,
    input  dtcm_rdata, ext_ready, ext_rvalid, ext_rdata
  );

  modport slave (
    input  dtcm_en, dtcm_we, dtcm_addr, dtcm_wdata,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_rready,
    output dtcm_rdata, ext_ready, ext_rvalid, ext_rdata
  );
endinterface

// File: rtl/dtcm_responder.sv
// rtl/dtcm_responder.sv - DTCM data SRAM responder with core-priority external port
module dtcm_responder #(
  parameter int AW        = 12,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  dtcm_responder_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] core_idx;
  logic [AW-1:0] ext_idx;
  logic          core_rd;
  logic          core_wr;
  logic          ext_ready;
  logic          ext_acc;
  logic          ext_rd;
  logic          ext_wr;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // Byte-offset and high address bits carry no meaning here; addresses alias.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{bus.dtcm_addr[31:AW+2], bus.dtcm_addr[1:0],
                              bus.ext_addr[31:AW+2], bus.ext_addr[1:0]};

  assign core_idx = bus.dtcm_addr[AW+1:2];
  assign ext_idx  = bus.ext_addr[AW+1:2];
  assign core_rd  = bus.dtcm_en && (bus.dtcm_we == 4'b0000);
  assign core_wr  = bus.dtcm_en && (bus.dtcm_we != 4'b0000);
  assign ext_acc  = bus.ext_valid && ext_ready;
  assign ext_rd   = ext_acc && (bus.ext_we == 4'b0000);
  assign ext_wr   = ext_acc && (bus.ext_we != 4'b0000);

  // External accesses are only accepted when the core is idle, so one shared
  // write port is enough; the core wins the mux by construction anyway.
  assign wr_en   = core_wr || ext_wr;
  assign wr_idx  = core_wr ? core_idx       : ext_idx;
  assign wr_be   = core_wr ? bus.dtcm_we    : bus.ext_we;
  assign wr_data = core_wr ? bus.dtcm_wdata : bus.ext_wdata;

  assign bus.ext_ready  = ext_ready;
  assign bus.ext_rvalid = (state == RESP);

  // Simulation convenience only: the array has no reset, this just clears X.
  generate
    if (INIT_ZERO) begin : g_init_zero
`ifndef SYNTHESIS
      initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
`endif
    end
  endgenerate

  // Array write with per-lane byte strobes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Core read data register: loaded only by core reads, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dtcm_rdata <= '0;
    end else if (core_rd) begin
      bus.dtcm_rdata <= mem[core_idx];
    end
  end

  // External read snapshot: later array writes must not disturb a pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ext_rdata <= '0;
    end else if (ext_rd) begin
      bus.ext_rdata <= mem[ext_idx];
    end
  end

  // External port state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accept external requests only in IDLE with no core access; a read parks in
  // RESP until the response is consumed, so no request is taken that cycle.
  always_comb begin
    state_next = state;
    ext_ready  = 1'b0;
    case (state)
      IDLE: begin
        ext_ready = ~bus.dtcm_en;
        if (bus.ext_valid && ~bus.dtcm_en && (bus.ext_we == 4'b0000)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.ext_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtcm_responder.sv
// tb/tb_dtcm_responder.sv - directed vector table plus randomized model check of dtcm_responder
module tb_dtcm_responder;

  localparam int MEM_WORDS = 4096;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dtcm_responder_if bus ();

  dtcm_responder #(.AW(12), .INIT_ZERO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] m_rdata;
  logic [31:0] m_erdata;
  bit          m_resp;
  bit          m_ready;
  logic        s_ready;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ev;
    logic [3:0]  ewe;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic        rr;
    logic        x_ready;
    logic [31:0] x_rdata;
    logic        x_rvalid;
    logic [31:0] x_erdata;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ev, input logic [3:0] ewe,
                              input logic [31:0] eaddr, input logic [31:0] ewdata,
                              input logic rr, input logic xr, input logic [31:0] xd,
                              input logic xv, input logic [31:0] xe);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ev = ev; v.ewe = ewe; v.eaddr = eaddr; v.ewdata = ewdata; v.rr = rr;
    v.x_ready = xr; v.x_rdata = xd; v.x_rvalid = xv; v.x_erdata = xe;
    return v;
  endfunction

  // One clock cycle: apply inputs, sample ext_ready before the edge, advance
  // the model by the memory's rules, and return #1 after the edge.
  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ev, input logic [3:0] ewe,
                       input logic [31:0] eaddr, input logic [31:0] ewdata, input logic rr);
    int ci, ei;
    bus.dtcm_en = en; bus.dtcm_we = we; bus.dtcm_addr = addr; bus.dtcm_wdata = wdata;
    bus.ext_valid = ev; bus.ext_we = ewe; bus.ext_addr = eaddr; bus.ext_wdata = ewdata;
    bus.ext_rready = rr;
    #1;
    s_ready = bus.ext_ready;
    ci = int'((addr / 4) % MEM_WORDS);
    ei = int'((eaddr / 4) % MEM_WORDS);
    m_ready = !m_resp && !en;
    if (en && we == 4'b0000) m_rdata = ref_mem[ci];
    else if (en) ref_mem[ci] = merge(ref_mem[ci], wdata, we);
    if (m_resp) begin
      if (rr) m_resp = 1'b0;
    end else if (ev && m_ready) begin
      if (ewe == 4'b0000) begin
        m_erdata = ref_mem[ei];
        m_resp   = 1'b1;
      end else begin
        ref_mem[ei] = merge(ref_mem[ei], ewdata, ewe);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_C000) | (($urandom() % 16) << 2) | ($urandom() % 4);
    return a;
  endfunction

  initial begin
    bit          p_valid;
    logic [3:0]  p_we;
    logic [31:0] p_addr, p_wdata;
    logic        r_en;
    logic [3:0]  r_we;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    m_rdata = '0; m_erdata = '0; m_resp = 1'b0; m_ready = 1'b0;

    reset = 1'b1;
    bus.dtcm_en = 1'b0; bus.dtcm_we = '0; bus.dtcm_addr = '0; bus.dtcm_wdata = '0;
    bus.ext_valid = 1'b0; bus.ext_we = '0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.ext_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata",  bus.dtcm_rdata, 32'h0);
    chk("rst_rvalid", bus.ext_rvalid, 32'h0);
    chk("rst_erdata", bus.ext_rdata,  32'h0);
    chk("rst_ready",  bus.ext_ready,  32'h1);
    reset = 1'b0;

    //             en we    addr         wdata         ev ewe   eaddr        ewdata        rr rdy rdata         rv erdata
    vecs[0]  = mk(1, 4'hF, 32'h10,      32'hDEADBEEF, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 4'h0, 32'h10,      32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0);
    vecs[2]  = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[3]  = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[4]  = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[5]  = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[6]  = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[7]  = mk(1, 4'hF, 32'h20,      32'h11223344, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0);
    vecs[8]  = mk(1, 4'h5, 32'h20,      32'hAABBCCDD, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0);
    vecs[9]  = mk(1, 4'h0, 32'h20,      32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h11BB33DD, 0, 32'h0);
    vecs[10] = mk(1, 4'hF, 32'h40,      32'hCAFEF00D, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h11BB33DD, 0, 32'h0);
    vecs[11] = mk(1, 4'hF, 32'h80,      32'h1,        1, 4'h0, 32'h40,     32'h0,        0, 0, 32'h11BB33DD, 0, 32'h0);
    vecs[12] = mk(1, 4'hF, 32'h80,      32'h2,        1, 4'h0, 32'h40,     32'h0,        0, 0, 32'h11BB33DD, 0, 32'h0);
    vecs[13] = mk(1, 4'hF, 32'h80,      32'h3,        1, 4'h0, 32'h40,     32'h0,        0, 0, 32'h11BB33DD, 0, 32'h0);
    vecs[14] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'h0, 32'h40,     32'h0,        0, 1, 32'h11BB33DD, 1, 32'hCAFEF00D);
    vecs[15] = mk(1, 4'hF, 32'h40,      32'h12345678, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h11BB33DD, 1, 32'hCAFEF00D);
    vecs[16] = mk(1, 4'hF, 32'h40,      32'h12345678, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h11BB33DD, 1, 32'hCAFEF00D);
    vecs[17] = mk(1, 4'hF, 32'h40,      32'h12345678, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h11BB33DD, 1, 32'hCAFEF00D);
    vecs[18] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'h0, 32'h40,     32'h0,        0, 0, 32'h11BB33DD, 1, 32'hCAFEF00D);
    vecs[19] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'h0, 32'h40,     32'h0,        1, 0, 32'h11BB33DD, 0, 32'hCAFEF00D);
    vecs[20] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'h0, 32'h40,     32'h0,        0, 1, 32'h11BB33DD, 1, 32'h12345678);
    vecs[21] = mk(0, 4'h0, 32'h0,       32'h0,        0, 4'h0, 32'h0,      32'h0,        1, 0, 32'h11BB33DD, 0, 32'h12345678);
    vecs[22] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'hF, 32'h4004,   32'h5A5A5A5A, 0, 1, 32'h11BB33DD, 0, 32'h12345678);
    vecs[23] = mk(1, 4'h0, 32'h4,       32'h0,        0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h5A5A5A5A, 0, 32'h12345678);
    vecs[24] = mk(0, 4'h0, 32'h0,       32'h0,        1, 4'h0, 32'h7,      32'h0,        0, 1, 32'h5A5A5A5A, 1, 32'h5A5A5A5A);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ev, vecs[i].ewe,
            vecs[i].eaddr, vecs[i].ewdata, vecs[i].rr);
      chk($sformatf("v%0d_ready", i),  s_ready,        vecs[i].x_ready);
      chk($sformatf("v%0d_rdata", i),  bus.dtcm_rdata, vecs[i].x_rdata);
      chk($sformatf("v%0d_rvalid", i), bus.ext_rvalid, vecs[i].x_rvalid);
      chk($sformatf("v%0d_erdata", i), bus.ext_rdata,  vecs[i].x_erdata);
    end

    // Asynchronous reset while a response is pending, between clock edges.
    bus.dtcm_en = 1'b0; bus.ext_valid = 1'b0; bus.ext_rready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_rvalid", bus.ext_rvalid, 32'h0);
    chk("arst_rdata",  bus.dtcm_rdata, 32'h0);
    chk("arst_erdata", bus.ext_rdata,  32'h0);
    #2 reset = 1'b0;
    m_rdata = '0; m_erdata = '0; m_resp = 1'b0;

    drive(1, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    chk("post_rst_0x20", bus.dtcm_rdata, 32'h11BB33DD);
    drive(1, 4'h0, 32'h4004, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    chk("post_rst_0x4004", bus.dtcm_rdata, 32'h5A5A5A5A);
    drive(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h10, 32'h0, 0);
    chk("post_rst_ext_rvalid", bus.ext_rvalid, 32'h1);
    chk("post_rst_ext_0x10",   bus.ext_rdata,  32'hDEADBEEF);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);

    // Give the random window defined contents before any read of it.
    for (int w = 0; w < 16; w++) drive(1, 4'hF, w << 2, $urandom(), 0, 4'h0, 32'h0, 32'h0, 1);

    p_valid = 1'b0; p_we = '0; p_addr = '0; p_wdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (!p_valid && ($urandom() % 3 != 0)) begin
        p_valid = 1'b1;
        p_we    = ($urandom() % 2) ? 4'h0 : 4'($urandom() % 16);
        p_addr  = rnd_addr();
        p_wdata = $urandom();
      end
      r_en = ($urandom() % 2) == 1;
      r_we = ($urandom() % 2) ? 4'h0 : 4'($urandom() % 16);
      drive(r_en, r_we, rnd_addr(), $urandom(), p_valid, p_we, p_addr, p_wdata,
            1'(($urandom() % 2)));
      chk("rnd_ready",  s_ready,        m_ready);
      chk("rnd_rdata",  bus.dtcm_rdata, m_rdata);
      chk("rnd_rvalid", bus.ext_rvalid, m_resp);
      chk("rnd_erdata", bus.ext_rdata,  m_erdata);
      if (p_valid && m_ready) p_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtcm_responder.md
Name: dtcm_responder

Overview:
- Responder end of the core's DTCM interface: a single-port word-addressed data SRAM with byte-write strobes.
- Returns read data one cycle after the request and holds it until the next core read.
- A secondary external port (loader/debug) shares the array through a valid/ready handshake. The core always has priority, so the external port sees back-pressure.
- Sits beside the memory-access stage. Instantiated once per core.

Parameters:
- AW, 12, word-address width; array holds 2**AW 32-bit words.
- INIT_ZERO, 0, when 1 the array contents are not initialised by reset but a simulation-only initial block zeroes them.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- dtcm_en  input  1  core request this cycle
- dtcm_we  input  4  core byte-write strobes; 0000 = read
- dtcm_addr  input  32  core byte address
- dtcm_wdata  input  32  core write data
- dtcm_rdata  output  32  core read data, valid cycle after read request, held until next core read
- ext_valid  input  1  external request valid
- ext_ready  output  1  external request accepted this cycle
- ext_we  input  4  external byte strobes; 0000 = read
- ext_addr  input  32  external byte address
- ext_wdata  input  32  external write data
- ext_rvalid  output  1  external read data valid
- ext_rready  input  1  external read data consumed
- ext_rdata  output  32  external read data

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: dtcm_rdata=0, ext_rvalid=0, ext_rdata=0, FSM=IDLE. Array contents are not reset.
- Addressing:
  - Word index = addr[AW+1:2]. addr[1:0] ignored.
  - Bits above AW+1 ignored, so addresses alias modulo 2**(AW+2).
- Byte strobes: we[i] writes byte lane i (bits 8i+7:8i). Other lanes are unchanged.
- Core read (dtcm_en=1, dtcm_we=0): dtcm_rdata updates at that clock edge and is valid the next cycle. It holds its value through idle cycles, core writes and external accesses.
- Core write (dtcm_en=1, dtcm_we!=0): array updates at the edge; dtcm_rdata is unchanged.
- Core read and write in the same cycle is impossible through a single strobe field; we!=0 means a write.
- Arbitration:
  - Core has absolute priority; the core never stalls.
  - ext_ready = (state==IDLE) & ~dtcm_en. ext_ready is a combinational function of dtcm_en and state.
- External FSM:
  - IDLE:
    - ext_valid & ext_ready & ext_we!=0 → array written at the edge; stay IDLE.
    - ext_valid & ext_ready & ext_we==0 → array read at the edge, ext_rdata loaded, ext_rvalid←1, go RESP.
  - RESP:
    - ext_rvalid=1 and ext_rdata is stable; ext_ready=0.
    - ext_rready=1 → ext_rvalid←0, go IDLE. A new external request may be accepted the following cycle, never in the same cycle.
  - Core accesses proceed normally while in RESP. ext_rdata is a snapshot and is not updated by later core writes.
- Ordering:
  - A core write followed by an external read of the same word returns the new data.
  - An external write at edge N is visible to a core read issued at edge N+1 or later.
- ext_valid deasserted without ready: no effect. The requester must hold its request fields stable while ext_valid=1 and ext_ready=0.
- Reset asserted mid-RESP: ext_rvalid drops immediately and the FSM returns to IDLE. Array data written before reset is retained.
- Implementation: one read port and one write port per cycle suffices, since core and external accesses are mutually exclusive per cycle.

Test Plan:
- Reset, core read of 0x0000_0010 after writing 0xDEADBEEF with we=1111 → dtcm_rdata=0xDEADBEEF one cycle after the read, held over 5 idle cycles.
- Byte-merge: write 0x11223344 we=1111 to 0x20, then 0xAABBCCDD we=0101 → read of 0x20 returns 0x11BB33DD.
- Priority: ext_valid=1 read of 0x40 while dtcm_en=1 for 3 cycles → ext_ready=0 for those cycles, accepted the first cycle dtcm_en=0. ext_rvalid rises next cycle with the correct data.
- RESP hold: ext read accepted, ext_rready=0 for 4 cycles while the core writes the same word → ext_rdata keeps the old value and ext_ready=0. Drop ext_rready after 1 cycle of high → next request accepted one cycle later.
- Aliasing: AW=12, write 0x5A5A5A5A to 0x0000_4004 → core read of 0x0000_0004 returns 0x5A5A5A5A.
- Async reset during RESP → ext_rvalid=0 and dtcm_rdata=0 without a clock edge. After release, data written before reset reads back unchanged.
